// File: rtl/mac_tile_engine_pkg.sv
// Shared types and helpers for the MAC tile engine: FSM encoding, width math, saturation.
package mac_pkg;
  typedef enum logic [2:0] {IDLE, CHKERR, LDW, LDI, MAC, WR, FIN} state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Full-precision accumulator: product width plus one bit per doubling of terms.
  function automatic int accw(input int dw, input int lanes);
    return 2 * dw + clog2(lanes);
  endfunction

  function automatic logic signed [63:0] sat(input logic signed [63:0] acc, input int dw);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (acc > hi) return hi;
    if (acc < lo) return lo;
    return acc;
  endfunction
endpackage

// File: rtl/mac_tile_engine_if.sv
// Memory-side bus of the MAC tile engine: I/W read ports and O write port.
interface mac_mem_if #(
  parameter int DW    = 16,
  parameter int LANES = 4,
  parameter int AW_I  = 3,
  parameter int AW_W  = 3,
  parameter int AW_O  = 4
);
  logic                  EN_I;
  logic [AW_I-1:0]       ADDR_I;
  logic [LANES*DW-1:0]   RDATA_I;
  logic                  EN_W;
  logic [AW_W-1:0]       ADDR_W;
  logic [LANES*DW-1:0]   RDATA_W;
  logic                  EN_O;
  logic                  RW_O;
  logic [AW_O-1:0]       ADDR_O;
  logic [LANES*DW-1:0]   WDATA_O;

  modport master (output EN_I, ADDR_I, EN_W, ADDR_W, EN_O, RW_O, ADDR_O, WDATA_O,
                  input  RDATA_I, RDATA_W);
  modport slave  (input  EN_I, ADDR_I, EN_W, ADDR_W, EN_O, RW_O, ADDR_O, WDATA_O,
                  output RDATA_I, RDATA_W);
endinterface

// File: rtl/mac_tile_engine_lane.sv
// One output lane: signed MAC with clear-on-first and a wrap/saturate output stage.
module mac_lane
  import mac_pkg::*;
#(
  parameter int DW   = 16,
  parameter int ACCW = 34
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 en,
  input  logic                 first,
  input  logic                 mode,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic        [DW-1:0] y
);
  logic signed [ACCW-1:0] acc;
  logic signed [2*DW-1:0] prod;

  assign prod = (2*DW)'(a) * (2*DW)'(b);

  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN)   acc <= '0;
    else if (en) acc <= (first ? '0 : acc) + ACCW'(prod);

  assign y = mode ? DW'(sat(64'(acc), DW)) : acc[DW-1:0];
endmodule

// File: rtl/mac_tile_engine.sv
// O = I x W tile engine: caches W rows, streams I rows through LANES parallel MACs.
module mac_tile_engine
  import mac_pkg::*;
#(
  parameter int DW    = 16,
  parameter int LANES = 4,
  parameter int MAX_M = 8,
  parameter int AW_I  = 3,
  parameter int AW_W  = 3,
  parameter int AW_O  = 4
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        START,
  input  logic [11:0] MNT,
  input  logic        MODE,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  mac_mem_if.master   mem
);
  localparam int ACCW = accw(DW, LANES);
  typedef logic [LANES-1:0][DW-1:0] row_t;

  state_t        state, nxt;
  logic [3:0]    m_q, n_q, t_q, row, cnt;
  logic          mode_q, dim_bad, lane_en, first;
  row_t          wc [LANES];
  row_t          irow_q, irow, rdw, wmask, wdata, lane_y, b_sel;
  logic [DW-1:0] a_sel;

  assign dim_bad = (MNT[11:8] == 4'd0) || (MNT[7:4] == 4'd0) || (MNT[3:0] == 4'd0) ||
                   (int'(MNT[11:8]) > MAX_M) || (int'(MNT[7:4]) > LANES) ||
                   (int'(MNT[3:0]) > LANES);

  assign rdw  = mem.RDATA_W;
  assign irow = (cnt == 4'd0) ? row_t'(mem.RDATA_I) : irow_q;

  // Operand k of the current term: one element of the I row, one cached W row.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int j = 0; j < LANES; j++)
      if (cnt == 4'(j)) begin
        a_sel = irow[j];
        b_sel = wc[j];
      end
  end

  for (genvar t = 0; t < LANES; t++) begin : g_lane
    mac_lane #(.DW(DW), .ACCW(ACCW)) u_lane (
      .CLK  (CLK),
      .RSTN (RSTN),
      .en   (lane_en),
      .first(first),
      .mode (mode_q),
      .a    (a_sel),
      .b    (b_sel[t]),
      .y    (lane_y[t])
    );
    assign wmask[t] = (4'(t) < t_q) ? rdw[t]    : '0;
    assign wdata[t] = (4'(t) < t_q) ? lane_y[t] : '0;
  end

  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) state <= IDLE;
    else       state <= nxt;

  always_comb begin
    nxt         = state;
    BUSY        = (state != IDLE);
    DONE        = 1'b0;
    ERR         = 1'b0;
    lane_en     = 1'b0;
    first       = 1'b0;
    mem.EN_I    = 1'b0;
    mem.ADDR_I  = '0;
    mem.EN_W    = 1'b0;
    mem.ADDR_W  = '0;
    mem.EN_O    = 1'b0;
    mem.RW_O    = 1'b0;
    mem.ADDR_O  = '0;
    mem.WDATA_O = '0;
    case (state)
      IDLE:   if (START) nxt = dim_bad ? CHKERR : LDW;
      CHKERR: begin DONE = 1'b1; ERR = 1'b1; nxt = IDLE; end
      LDW: begin
        if (cnt < n_q) begin
          mem.EN_W   = 1'b1;
          mem.ADDR_W = AW_W'(cnt);
        end
        if (cnt == n_q) nxt = LDI;
      end
      LDI: begin mem.EN_I = 1'b1; mem.ADDR_I = AW_I'(row); nxt = MAC; end
      MAC: begin
        lane_en = 1'b1;
        first   = (cnt == 4'd0);
        if (cnt == n_q - 4'd1) nxt = WR;
      end
      WR: begin
        mem.EN_O    = 1'b1;
        mem.RW_O    = 1'b1;
        mem.ADDR_O  = AW_O'(row);
        mem.WDATA_O = wdata;
        nxt         = (row == m_q - 4'd1) ? FIN : LDI;
      end
      FIN:     begin DONE = 1'b1; nxt = IDLE; end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      m_q <= '0; n_q <= '0; t_q <= '0; mode_q <= 1'b0;
      row <= '0; cnt <= '0; irow_q <= '0;
      for (int j = 0; j < LANES; j++) wc[j] <= '0;
    end else begin
      case (state)
        IDLE: if (START) begin
          m_q <= MNT[11:8]; n_q <= MNT[7:4]; t_q <= MNT[3:0]; mode_q <= MODE;
          cnt <= '0; row <= '0;
        end
        // Read data for W row cnt-1 lands one cycle after its address.
        LDW: begin
          for (int j = 0; j < LANES; j++)
            if (cnt == 4'(j + 1)) wc[j] <= wmask;
          cnt <= (cnt == n_q) ? 4'd0 : cnt + 4'd1;
        end
        MAC: begin
          if (cnt == 4'd0) irow_q <= mem.RDATA_I;
          cnt <= (cnt == n_q - 4'd1) ? 4'd0 : cnt + 4'd1;
        end
        WR:      row <= row + 4'd1;
        default: ;
      endcase
    end
endmodule
